// File: rtl/lotr_pkg.sv
// Shared types and defaults for the Ring Controller (RC) ring datapath.
package lotr_pkg;

    // Owner of the outgoing ring slot. This type is shared with the C2F and F2C buffers.
    typedef enum logic [1:0] {
        RING_FORWARD = 2'd0,
        C2F_REQUEST  = 2'd1,
        F2C_RESPONSE = 2'd2
    } t_winner;

    // Ring transaction opcodes.
    typedef enum logic [2:0] {
        NOP    = 3'd0,
        RD     = 3'd1,
        WR     = 3'd2,
        RD_RSP = 3'd3,
        WR_RSP = 3'd4
    } t_opcode;

    // Default number of C2F reads that may be outstanding at once.
    localparam int RD_CREDITS_DFLT   = 4;
    // Default number of consecutive blocked cycles before a source is starving.
    localparam int STARVE_LIMIT_DFLT = 15;

endpackage

// File: rtl/rc_wait_cnt.sv
// Saturating count of consecutive cycles that a local source has waited for the ring slot.
module rc_wait_cnt #(
    parameter int LIMIT = 15
) (
    input  logic                         QClk,
    input  logic                         RstQnnnL,
    input  logic                         Valid,
    input  logic                         Grant,
    output logic [$clog2(LIMIT+1)-1:0]   Count,
    output logic                         AtLimit
);

    localparam int                W       = $clog2(LIMIT + 1);
    localparam logic [W-1:0]      CNT_MAX = W'(LIMIT);

    assign AtLimit = (Count == CNT_MAX);

    // Count blocked cycles, hold at LIMIT, and restart when the source is served or withdraws.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        // NOTE: state flops use non-blocking assignments so that every flop samples
        // pre-edge values. A blocking assignment here would create ordering races.
        if (!RstQnnnL) begin
            Count <= '0;
        end else if (!Valid || Grant) begin
            Count <= '0;
        end else if (!AtLimit) begin
            Count <= Count + 1'b1;
        end
    end

endmodule

// File: rtl/rc_ring_out_arb.sv
// Ring-output slot arbiter. It selects between ring forward, C2F requests and F2C
// responses. It applies a read-credit limit on C2F reads and round-robin fairness
// with starvation override between the two local sources.
module rc_ring_out_arb
    import lotr_pkg::*;
#(
    parameter int RD_CREDITS   = RD_CREDITS_DFLT,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DFLT
) (
    input  logic        QClk,
    input  logic        RstQnnnL,
    input  logic [7:0]  CoreID,
    input  logic        RingFwdValidQ501H,
    input  logic        F2C_RspValidQ501H,
    input  logic        C2F_ReqValidQ501H,
    input  t_opcode     C2F_ReqOpcodeQ501H,
    input  logic        RingRspInValidQ501H,
    input  t_opcode     RingRspInOpcodeQ501H,
    input  logic [9:0]  RingRspInRequestorQ501H,
    output t_winner     SelRingReqOutQ501H,
    output logic        C2F_GrantQ501H,
    output logic        F2C_GrantQ501H,
    output logic [3:0]  C2F_RdCreditsQnnnH,
    output logic        StarveQnnnH,
    output logic        CreditErrQnnnH
);

    localparam int               CNT_W    = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STARVE_LIMIT);
    localparam logic [3:0]       CRED_MAX = 4'(RD_CREDITS);

    logic [3:0]       credits;
    logic             last_c2f;      // 1: the most recent local grant went to C2F
    logic             cred_err;
    logic             f2c_elig;
    logic             c2f_elig;
    logic             f2c_at_limit;
    logic             c2f_at_limit;
    logic [CNT_W-1:0] f2c_cnt;
    logic [CNT_W-1:0] c2f_cnt;
    logic             rd_take;
    logic             cred_ret;
    logic             unused_thread;

    // The thread bits of the requestor do not affect credit ownership.
    assign unused_thread = ^RingRspInRequestorQ501H[1:0];

    // A C2F read is eligible only while a credit is available. Writes are always eligible.
    assign f2c_elig = F2C_RspValidQ501H;
    assign c2f_elig = C2F_ReqValidQ501H &&
                      ((C2F_ReqOpcodeQ501H != RD) || (credits != 4'd0));

    // Slot winner: ring forward first, then a lone eligible source, then a starving
    // source, then round-robin. The select is held at forward while reset is asserted.
    always_comb begin
        // NOTE: the default assignment covers every path through this block, so no latch is inferred.
        SelRingReqOutQ501H = RING_FORWARD;
        if (RstQnnnL && !RingFwdValidQ501H) begin
            if (f2c_elig && c2f_elig) begin
                if (f2c_at_limit && !c2f_at_limit) begin
                    SelRingReqOutQ501H = F2C_RESPONSE;
                end else if (c2f_at_limit && !f2c_at_limit) begin
                    SelRingReqOutQ501H = C2F_REQUEST;
                end else begin
                    SelRingReqOutQ501H = last_c2f ? F2C_RESPONSE : C2F_REQUEST;
                end
            end else if (f2c_elig) begin
                SelRingReqOutQ501H = F2C_RESPONSE;
            end else if (c2f_elig) begin
                SelRingReqOutQ501H = C2F_REQUEST;
            end
        end
    end

    assign C2F_GrantQ501H = (SelRingReqOutQ501H == C2F_REQUEST);
    assign F2C_GrantQ501H = (SelRingReqOutQ501H == F2C_RESPONSE);

    assign rd_take  = C2F_GrantQ501H && (C2F_ReqOpcodeQ501H == RD);
    assign cred_ret = RingRspInValidQ501H && (RingRspInOpcodeQ501H == RD_RSP) &&
                      (RingRspInRequestorQ501H[9:2] == CoreID);

    // Round-robin pointer. It moves only on local grants, so forward cycles keep the order.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            last_c2f <= 1'b1;
        end else if (C2F_GrantQ501H) begin
            last_c2f <= 1'b1;
        end else if (F2C_GrantQ501H) begin
            last_c2f <= 1'b0;
        end
    end

    // Read-credit pool. A simultaneous take and return cancel out. A return into a full pool
    // is held at the maximum and flagged.
    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            credits  <= CRED_MAX;
            cred_err <= 1'b0;
        end else if (cred_ret && !rd_take) begin
            if (credits == CRED_MAX) begin
                cred_err <= 1'b1;
            end else begin
                credits <= credits + 4'd1;
            end
        end else if (rd_take && !cred_ret) begin
            credits <= credits - 4'd1;
        end
    end

    rc_wait_cnt #(.LIMIT(STARVE_LIMIT)) u_f2c_wait (
        .QClk    (QClk),
        .RstQnnnL(RstQnnnL),
        .Valid   (F2C_RspValidQ501H),
        .Grant   (F2C_GrantQ501H),
        .Count   (f2c_cnt),
        .AtLimit (f2c_at_limit)
    );

    // A C2F read that is blocked on zero credits still counts as waiting.
    rc_wait_cnt #(.LIMIT(STARVE_LIMIT)) u_c2f_wait (
        .QClk    (QClk),
        .RstQnnnL(RstQnnnL),
        .Valid   (C2F_ReqValidQ501H),
        .Grant   (C2F_GrantQ501H),
        .Count   (c2f_cnt),
        .AtLimit (c2f_at_limit)
    );

    assign C2F_RdCreditsQnnnH = credits;
    assign CreditErrQnnnH     = cred_err;
    assign StarveQnnnH        = (f2c_cnt == CNT_MAX) || (c2f_cnt == CNT_MAX);

endmodule

// File: tb/tb_rc_ring_out_arb.sv
// Self-checking bench for rc_ring_out_arb. It uses a directed vector table, hand
// sequences and randomized traffic compared against a behavioural model.
module tb_rc_ring_out_arb;
    import lotr_pkg::*;

    localparam int         NCRED = 4;
    localparam int         SL    = 15;
    localparam logic [7:0] CORE  = 8'hA5;

    logic        QClk;
    logic        RstQnnnL;
    logic        RingFwdValidQ501H;
    logic        F2C_RspValidQ501H;
    logic        C2F_ReqValidQ501H;
    t_opcode     C2F_ReqOpcodeQ501H;
    logic        RingRspInValidQ501H;
    t_opcode     RingRspInOpcodeQ501H;
    logic [9:0]  RingRspInRequestorQ501H;
    t_winner     SelRingReqOutQ501H;
    logic        C2F_GrantQ501H;
    logic        F2C_GrantQ501H;
    logic [3:0]  C2F_RdCreditsQnnnH;
    logic        StarveQnnnH;
    logic        CreditErrQnnnH;

    rc_ring_out_arb #(.RD_CREDITS(NCRED), .STARVE_LIMIT(SL)) dut (
        .QClk                   (QClk),
        .RstQnnnL               (RstQnnnL),
        .CoreID                 (CORE),
        .RingFwdValidQ501H      (RingFwdValidQ501H),
        .F2C_RspValidQ501H      (F2C_RspValidQ501H),
        .C2F_ReqValidQ501H      (C2F_ReqValidQ501H),
        .C2F_ReqOpcodeQ501H     (C2F_ReqOpcodeQ501H),
        .RingRspInValidQ501H    (RingRspInValidQ501H),
        .RingRspInOpcodeQ501H   (RingRspInOpcodeQ501H),
        .RingRspInRequestorQ501H(RingRspInRequestorQ501H),
        .SelRingReqOutQ501H     (SelRingReqOutQ501H),
        .C2F_GrantQ501H         (C2F_GrantQ501H),
        .F2C_GrantQ501H         (F2C_GrantQ501H),
        .C2F_RdCreditsQnnnH     (C2F_RdCreditsQnnnH),
        .StarveQnnnH            (StarveQnnnH),
        .CreditErrQnnnH         (CreditErrQnnnH)
    );

    initial QClk = 1'b0;
    always #5 QClk = ~QClk;

    typedef struct packed {
        logic       fwd;
        logic       f2c;
        logic       c2f;
        t_opcode    op;
        logic       rv;
        t_opcode    rop;
        logic [7:0] rcore;
    } in_t;

    typedef struct {
        in_t     in;
        t_winner sel;
        int      cred;
        int      err;
    } vec_t;

    int errors;
    int checks;

    // Behavioural model state
    int      m_cred;
    int      m_wf;
    int      m_wc;
    bit      m_last_c2f;
    bit      m_err;
    t_winner m_sel;
    in_t     cur;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic in_t mk_in(bit fwd, bit f2c, bit c2f, t_opcode op,
                                  bit rv, t_opcode rop, logic [7:0] rcore);
        in_t v;
        v.fwd = fwd; v.f2c = f2c; v.c2f = c2f; v.op = op;
        v.rv = rv; v.rop = rop; v.rcore = rcore;
        return v;
    endfunction

    task automatic set_inputs(input in_t v);
        cur                     = v;
        RingFwdValidQ501H       = v.fwd;
        F2C_RspValidQ501H       = v.f2c;
        C2F_ReqValidQ501H       = v.c2f;
        C2F_ReqOpcodeQ501H      = v.op;
        RingRspInValidQ501H     = v.rv;
        RingRspInOpcodeQ501H    = v.rop;
        RingRspInRequestorQ501H = {v.rcore, 2'($urandom_range(0, 3))};
    endtask

    task automatic model_reset();
        m_cred = NCRED; m_wf = 0; m_wc = 0; m_last_c2f = 1'b1; m_err = 1'b0;
    endtask

    // Drive a cycle's inputs just after the falling edge, then let them settle.
    task automatic drive(input in_t v);
        @(negedge QClk);
        set_inputs(v);
        #1;
    endtask

    // Predict this cycle's decision from the arbitration rules and compare all outputs.
    task automatic check_model();
        bit f_ok, c_ok, f_st, c_st;
        f_ok = cur.f2c;
        c_ok = cur.c2f && (cur.op != RD || m_cred > 0);
        f_st = (m_wf == SL);
        c_st = (m_wc == SL);
        if (cur.fwd)            m_sel = RING_FORWARD;
        else if (f_ok && c_ok) begin
            if (f_st && !c_st)      m_sel = F2C_RESPONSE;
            else if (c_st && !f_st) m_sel = C2F_REQUEST;
            else                    m_sel = m_last_c2f ? F2C_RESPONSE : C2F_REQUEST;
        end
        else if (f_ok)          m_sel = F2C_RESPONSE;
        else if (c_ok)          m_sel = C2F_REQUEST;
        else                    m_sel = RING_FORWARD;
        check("sel",     int'(SelRingReqOutQ501H), int'(m_sel));
        check("c2f_gnt", int'(C2F_GrantQ501H),     int'(m_sel == C2F_REQUEST));
        check("f2c_gnt", int'(F2C_GrantQ501H),     int'(m_sel == F2C_RESPONSE));
        check("credits", int'(C2F_RdCreditsQnnnH), m_cred);
        check("starve",  int'(StarveQnnnH),        int'(f_st || c_st));
        check("crd_err", int'(CreditErrQnnnH),     int'(m_err));
    endtask

    // Clock edge: advance the model with the decision made this cycle.
    task automatic advance();
        int take, ret;
        @(posedge QClk);
        take = (m_sel == C2F_REQUEST && cur.op == RD) ? 1 : 0;
        ret  = (cur.rv && cur.rop == RD_RSP && cur.rcore == CORE) ? 1 : 0;
        m_cred = m_cred + ret - take;
        if (m_cred > NCRED) begin
            m_cred = NCRED;
            m_err  = 1'b1;
        end
        m_wf = (cur.f2c && m_sel != F2C_RESPONSE) ? ((m_wf < SL) ? m_wf + 1 : SL) : 0;
        m_wc = (cur.c2f && m_sel != C2F_REQUEST)  ? ((m_wc < SL) ? m_wc + 1 : SL) : 0;
        if (m_sel == F2C_RESPONSE) m_last_c2f = 1'b0;
        if (m_sel == C2F_REQUEST)  m_last_c2f = 1'b1;
    endtask

    task automatic do_reset();
        RstQnnnL = 1'b0;
        set_inputs(mk_in(0, 0, 0, NOP, 0, NOP, CORE));
        repeat (2) @(posedge QClk);
        @(negedge QClk);
        RstQnnnL = 1'b1;
        model_reset();
    endtask

    function automatic in_t rand_in(int fwd_pct);
        in_t v;
        v.fwd   = ($urandom_range(0, 99) < fwd_pct);
        v.f2c   = $urandom_range(0, 1) == 1;
        v.c2f   = $urandom_range(0, 1) == 1;
        v.op    = ($urandom_range(0, 3) != 0) ? RD : t_opcode'(3'($urandom_range(0, 4)));
        v.rv    = ($urandom_range(0, 3) == 0);
        v.rop   = ($urandom_range(0, 3) != 0) ? RD_RSP : t_opcode'(3'($urandom_range(0, 4)));
        v.rcore = ($urandom_range(0, 3) != 0) ? CORE : CORE ^ 8'($urandom_range(1, 255));
        return v;
    endfunction

    vec_t tbl[22];

    initial begin
        in_t idle, both_wr, rd_only, rsp_me;
        errors = 0;
        checks = 0;
        RstQnnnL = 1'b0;
        idle    = mk_in(0, 0, 0, NOP, 0, NOP, CORE);
        both_wr = mk_in(0, 1, 1, WR,  0, NOP, CORE);
        rd_only = mk_in(0, 0, 1, RD,  0, NOP, CORE);
        rsp_me  = mk_in(0, 0, 0, NOP, 1, RD_RSP, CORE);
        set_inputs(idle);
        model_reset();

        // Directed table: {inputs, select, visible credits, visible error flag}
        tbl[0]  = '{idle,    RING_FORWARD, 4, 0};
        tbl[1]  = '{both_wr, F2C_RESPONSE, 4, 0};
        tbl[2]  = '{both_wr, C2F_REQUEST,  4, 0};
        tbl[3]  = '{both_wr, F2C_RESPONSE, 4, 0};
        tbl[4]  = '{both_wr, C2F_REQUEST,  4, 0};
        tbl[5]  = '{rd_only, C2F_REQUEST,  4, 0};
        tbl[6]  = '{rd_only, C2F_REQUEST,  3, 0};
        tbl[7]  = '{rd_only, C2F_REQUEST,  2, 0};
        tbl[8]  = '{rd_only, C2F_REQUEST,  1, 0};
        tbl[9]  = '{rd_only, RING_FORWARD, 0, 0};
        tbl[10] = '{mk_in(0, 0, 1, RD, 1, RD_RSP, CORE), RING_FORWARD, 0, 0};
        tbl[11] = '{rd_only, C2F_REQUEST,  1, 0};
        tbl[12] = '{rsp_me,  RING_FORWARD, 0, 0};
        tbl[13] = '{rsp_me,  RING_FORWARD, 1, 0};
        tbl[14] = '{mk_in(0, 0, 1, RD, 1, RD_RSP, CORE), C2F_REQUEST, 2, 0};
        tbl[15] = '{idle,    RING_FORWARD, 2, 0};
        tbl[16] = '{mk_in(0, 0, 0, NOP, 1, RD_RSP, 8'h3C), RING_FORWARD, 2, 0};
        tbl[17] = '{idle,    RING_FORWARD, 2, 0};
        tbl[18] = '{rsp_me,  RING_FORWARD, 2, 0};
        tbl[19] = '{rsp_me,  RING_FORWARD, 3, 0};
        tbl[20] = '{rsp_me,  RING_FORWARD, 4, 0};
        tbl[21] = '{idle,    RING_FORWARD, 4, 1};

        do_reset();
        for (int i = 0; i < 22; i++) begin
            drive(tbl[i].in);
            check_model();
            check($sformatf("tbl%0d_sel", i),  int'(SelRingReqOutQ501H), int'(tbl[i].sel));
            check($sformatf("tbl%0d_cred", i), int'(C2F_RdCreditsQnnnH), tbl[i].cred);
            check($sformatf("tbl%0d_err", i),  int'(CreditErrQnnnH),     tbl[i].err);
            advance();
        end

        // Forward traffic starves F2C. Starve rises after STARVE_LIMIT blocked cycles.
        do_reset();
        for (int k = 0; k < 20; k++) begin
            drive(mk_in(1, 1, 0, NOP, 0, NOP, CORE));
            check_model();
            check("fwd_blocks_f2c", int'(F2C_GrantQ501H), 0);
            check("fwd_starve",     int'(StarveQnnnH),    int'(k >= SL));
            advance();
        end
        drive(mk_in(0, 1, 0, NOP, 0, NOP, CORE));
        check_model();
        check("starved_f2c_sel", int'(SelRingReqOutQ501H), int'(F2C_RESPONSE));
        check("starve_held",     int'(StarveQnnnH), 1);
        advance();
        drive(idle);
        check_model();
        check("starve_cleared", int'(StarveQnnnH), 0);
        advance();

        // A starving C2F beats the round-robin choice, which would otherwise favour F2C.
        do_reset();
        for (int k = 0; k < SL; k++) begin
            drive(mk_in(1, 0, 1, WR, 0, NOP, CORE));
            check_model();
            advance();
        end
        drive(both_wr);
        check_model();
        check("starve_override", int'(SelRingReqOutQ501H), int'(C2F_REQUEST));
        advance();

        // Asynchronous reset mid-burst, with credits at 1 and the wait counters nonzero.
        do_reset();
        for (int k = 0; k < 3; k++) begin
            drive(rd_only);
            check_model();
            advance();
        end
        for (int k = 0; k < 3; k++) begin
            drive(mk_in(1, 1, 1, RD, 0, NOP, CORE));
            check_model();
            advance();
        end
        drive(mk_in(0, 1, 1, RD, 0, NOP, CORE));
        check_model();
        check("pre_rst_cred", int'(C2F_RdCreditsQnnnH), 1);
        #2 RstQnnnL = 1'b0;
        #1;
        check("rst_sel",    int'(SelRingReqOutQ501H), int'(RING_FORWARD));
        check("rst_c2f",    int'(C2F_GrantQ501H), 0);
        check("rst_f2c",    int'(F2C_GrantQ501H), 0);
        check("rst_cred",   int'(C2F_RdCreditsQnnnH), NCRED);
        check("rst_starve", int'(StarveQnnnH), 0);
        @(posedge QClk);
        #1;
        check("rst_hold_sel", int'(SelRingReqOutQ501H), int'(RING_FORWARD));
        set_inputs(idle);
        @(negedge QClk);
        RstQnnnL = 1'b1;
        model_reset();
        drive(both_wr);
        check_model();
        check("post_rst_f2c_first", int'(SelRingReqOutQ501H), int'(F2C_RESPONSE));
        check("post_rst_err",       int'(CreditErrQnnnH), 0);
        advance();

        // Randomized traffic: a forward-heavy phase to reach starvation, then a mixed phase.
        do_reset();
        for (int k = 0; k < 300; k++) begin
            drive(rand_in(85));
            check_model();
            advance();
        end
        for (int k = 0; k < 500; k++) begin
            drive(rand_in(20));
            check_model();
            advance();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
